// File: rtl/tspi_pkg.sv
// Shared types and constants for the TSPI user-domain datapath.
package tspi_pkg;

  // Default parallel word width of the shift engine.
  localparam int unsigned TspiDefaultDataWidth = 32;

  // Word length minus one; same encoding as the counter's length command.
  typedef logic [5:0] tspi_len_t;

  // Shift engine FSM states.
  typedef enum logic [0:0] {
    StIdle,
    StShift
  } tspi_shift_state_e;

endpackage

// File: rtl/tspi_rx_slot.sv
// Single-entry valid/ready holding register for completed RX words.
// A write into an occupied, unconsumed slot overwrites it and flags overflow.
module tspi_rx_slot #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 overflow_o
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;

  // Slot occupancy and contents; a write always wins over a concurrent read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      data_q  <= wr_data_i;
    end else if (rd_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Overflow only when the old word is still pending and not being taken.
  always_comb begin
    overflow_o = wr_en_i && valid_q && !rd_ready_i;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tspi_shift_engine.sv
// TSPI bit-level serializer/deserializer. Shifts a TX word out MSB-first on
// sdo_o while shifting sdi_i into an RX word; word ends on last_bit_i.
// Optional feature: define TSPI_SHIFT_LEN_CHECK_EN to flag last_bit_i
// arriving out of step with the loaded word length on len_err_o.
module tspi_shift_engine
  import tspi_pkg::*;
#(
  parameter int unsigned DataWidth = TspiDefaultDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic [5:0]           tx_len_i,
  input  logic                 last_bit_i,
  output logic                 sdo_o,
  input  logic                 sdi_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 busy_o,
  output logic                 rx_overflow_o,
  output logic                 len_err_o
);

  localparam int unsigned IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  tspi_shift_state_e    state_q;
  logic [DataWidth-1:0] shreg_q;
  tspi_len_t            len_q;

  logic [DataWidth-1:0] shifted;
  logic [DataWidth-1:0] rx_mask;
  logic [DataWidth-1:0] rx_word;
  logic                 word_done;
  logic                 tx_accept;

  // Next shift value, RX length mask and handshake decode.
  always_comb begin
    shifted    = {shreg_q[DataWidth-2:0], sdi_i};
    // Shift by len+1 in 7 bits so len=63 on a 64-bit engine yields all ones.
    rx_mask    = ~({DataWidth{1'b1}} << ({1'b0, len_q} + 7'd1));
    rx_word    = shifted & rx_mask;
    busy_o     = (state_q == StShift);
    word_done  = busy_o && last_bit_i;
    tx_ready_o = (state_q == StIdle) || word_done;
    tx_accept  = tx_valid_i && tx_ready_o;
    // Registered-only path: state, shift register and length register.
    sdo_o      = busy_o && shreg_q[len_q[IdxW-1:0]];
  end

  // FSM and shift register; a finishing word can reload in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      len_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tx_valid_i) begin
            shreg_q <= tx_data_i;
            len_q   <= tx_len_i;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (tx_accept) begin
            shreg_q <= tx_data_i;
            len_q   <= tx_len_i;
          end else begin
            shreg_q <= shifted;
            if (word_done) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TSPI_SHIFT_LEN_CHECK_EN
  tspi_len_t bitcnt_q;

  // Bits shifted so far in the current word; restarts on every load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitcnt_q <= '0;
    end else if (tx_accept) begin
      bitcnt_q <= '0;
    end else if (busy_o) begin
      bitcnt_q <= bitcnt_q + 6'd1;
    end
  end

  // Flag last_bit_i disagreeing with the expected final bit position.
  always_comb begin
    len_err_o = busy_o && (last_bit_i != (bitcnt_q == len_q));
  end
`else
  assign len_err_o = 1'b0;
`endif

  tspi_rx_slot #(
    .DataWidth (DataWidth)
  ) u_rx_slot (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (word_done),
    .wr_data_i  (rx_word),
    .rd_ready_i (rx_ready_i),
    .valid_o    (rx_valid_o),
    .data_o     (rx_data_o),
    .overflow_o (rx_overflow_o)
  );

endmodule

// File: tb/tb_tspi_shift_engine.sv
// Directed self-checking bench for tspi_shift_engine with sdi looped back
// from sdo. Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_tspi_shift_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [5:0]  tx_len;
  logic        last_bit;
  logic        sdo;
  logic        sdi;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        busy;
  logic        rx_overflow;
  logic        len_err;

  int tests = 0;
  int fails = 0;

`ifdef TSPI_SHIFT_LEN_CHECK_EN
  localparam logic ExpLenErr = 1'b1;
`else
  localparam logic ExpLenErr = 1'b0;
`endif

  always #5 clk = ~clk;

  assign sdi = sdo;

  tspi_shift_engine #(
    .DataWidth (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .tx_data_i     (tx_data),
    .tx_len_i      (tx_len),
    .last_bit_i    (last_bit),
    .sdo_o         (sdo),
    .sdi_i         (sdi),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .rx_data_o     (rx_data),
    .busy_o        (busy),
    .rx_overflow_o (rx_overflow),
    .len_err_o     (len_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [15:0] pat16;

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_len   = '0;
    last_bit = 1'b0;
    rx_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_sdo", sdo, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk32("rst_rx_data", rx_data, 32'h0);
    chk1("rst_overflow", rx_overflow, 1'b0);
    chk1("rst_len_err", len_err, 1'b0);
    next_cycle();

    // Single word 0xA5, len 7
    pat      = 8'hA5;
    tx_valid = 1'b1;
    tx_data  = 32'hFFFF_FFA5;  // upper bits must be ignored
    tx_len   = 6'd7;
    @(negedge clk);
    chk1("single_accept_ready", tx_ready, 1'b1);
    next_cycle();
    tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      last_bit = (k == 7);
      @(negedge clk);
      chk1($sformatf("single_sdo_%0d", k), sdo, pat[7-k]);
      chk1($sformatf("single_busy_%0d", k), busy, 1'b1);
      chk1($sformatf("single_ready_%0d", k), tx_ready, k == 7);
      chk1($sformatf("single_rxv_%0d", k), rx_valid, 1'b0);
      next_cycle();
    end
    last_bit = 1'b0;
    @(negedge clk);
    chk1("single_rx_valid", rx_valid, 1'b1);
    chk32("single_rx_data", rx_data, 32'h0000_00A5);
    chk1("single_idle", busy, 1'b0);
    chk1("single_sdo_idle", sdo, 1'b0);

    // Consume the RX word
    rx_ready = 1'b1;
    next_cycle();
    rx_ready = 1'b0;
    @(negedge clk);
    chk1("consume_rx_valid", rx_valid, 1'b0);
    next_cycle();

    // Back-to-back 0x3 (len 1) then 0x5 (len 2), RX never consumed
    tx_valid = 1'b1;
    tx_data  = 32'h3;
    tx_len   = 6'd1;
    next_cycle();
    tx_data  = 32'h5;
    tx_len   = 6'd2;
    @(negedge clk);
    chk1("b2b_sdo0", sdo, 1'b1);
    chk1("b2b_ready0", tx_ready, 1'b0);
    next_cycle();
    last_bit = 1'b1;
    @(negedge clk);
    chk1("b2b_sdo1", sdo, 1'b1);
    chk1("b2b_ready1", tx_ready, 1'b1);
    chk1("b2b_ovf1", rx_overflow, 1'b0);
    next_cycle();
    tx_valid = 1'b0;
    last_bit = 1'b0;
    @(negedge clk);
    chk1("b2b_sdo2", sdo, 1'b1);
    chk1("b2b_busy2", busy, 1'b1);
    chk1("b2b_rxv2", rx_valid, 1'b1);
    chk32("b2b_rxd2", rx_data, 32'h3);
    next_cycle();
    @(negedge clk);
    chk1("b2b_sdo3", sdo, 1'b0);
    chk1("b2b_ready3", tx_ready, 1'b0);
    next_cycle();
    last_bit = 1'b1;
    @(negedge clk);
    chk1("b2b_sdo4", sdo, 1'b1);
    chk1("b2b_ready4", tx_ready, 1'b1);
    chk1("ovf_pulse", rx_overflow, 1'b1);
    next_cycle();
    last_bit = 1'b0;
    @(negedge clk);
    chk1("ovf_rx_valid", rx_valid, 1'b1);
    chk32("ovf_rx_data", rx_data, 32'h5);
    chk1("ovf_pulse_end", rx_overflow, 1'b0);
    chk1("b2b_idle", busy, 1'b0);
    next_cycle();

    // 1-bit word written while slot full but consumed in the same cycle
    tx_valid = 1'b1;
    tx_data  = 32'h1;
    tx_len   = 6'd0;
    next_cycle();
    tx_valid = 1'b0;
    last_bit = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    chk1("len0_sdo", sdo, 1'b1);
    chk1("len0_ready", tx_ready, 1'b1);
    chk1("noovf_pulse", rx_overflow, 1'b0);
    next_cycle();
    last_bit = 1'b0;
    rx_ready = 1'b0;
    @(negedge clk);
    chk1("len0_rx_valid", rx_valid, 1'b1);
    chk32("len0_rx_data", rx_data, 32'h1);
    chk1("len0_idle", busy, 1'b0);
    next_cycle();

    // Reset at the 3rd bit of a len 15 transfer, with an RX word pending
    pat16    = 16'hBEEF;
    tx_valid = 1'b1;
    tx_data  = 32'h0000_BEEF;
    tx_len   = 6'd15;
    next_cycle();
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rst = (k == 2);
      @(negedge clk);
      chk1($sformatf("rstmid_sdo_%0d", k), sdo, pat16[15-k]);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_sdo", sdo, 1'b0);
    chk1("rstmid_rx_valid", rx_valid, 1'b0);
    chk1("rstmid_tx_ready", tx_ready, 1'b1);
    chk32("rstmid_rx_data", rx_data, 32'h0);
    next_cycle();

    // last_bit early: len 7, ends at 6th bit
    pat      = 8'hA5;
    tx_valid = 1'b1;
    tx_data  = 32'hA5;
    tx_len   = 6'd7;
    next_cycle();
    tx_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      last_bit = (k == 5);
      @(negedge clk);
      chk1($sformatf("lenchk_sdo_%0d", k), sdo, pat[7-k]);
      if (k == 0) chk1("lenchk_no_err", len_err, 1'b0);
      if (k == 5) chk1("lenchk_err", len_err, ExpLenErr);
      next_cycle();
    end
    last_bit = 1'b0;
    @(negedge clk);
    chk1("lenchk_idle", busy, 1'b0);
    chk1("lenchk_rx_valid", rx_valid, 1'b1);
    chk32("lenchk_rx_data", rx_data, 32'h69);
    chk1("lenchk_err_end", len_err, 1'b0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
